// File: rtl/ternary_serial_adder.sv
// ternary_serial_adder
//   Trit-serial balanced-ternary adder. Accepts one pair of encoded trits per
//   handshake, least-significant trit first, adds them with a registered carry
//   and emits one encoded sum trit per beat through a single-entry output
//   register with no skid buffer.
//
//   Trit encoding: 00 = -1, 01 = 0, 10 = +1, 11 = illegal (read as 0, sets err).
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   in_valid   : upstream presents a trit pair on in_a/in_b
//   in_ready   : pair is accepted this cycle
//   in_a, in_b : operand trits
//   out_valid  : out_sum/out_carry/out_last hold a result
//   out_ready  : downstream consumes the result this cycle
//   out_sum    : sum trit
//   out_carry  : carry trit produced by this beat
//   out_last   : this beat is trit WORD_TRITS-1 of the word
//   err        : sticky illegal-input-code flag, cleared only by reset
module ternary_serial_adder #(
   parameter int unsigned WORD_TRITS = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_a,
   input  logic [1:0] in_b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_sum,
   output logic [1:0] out_carry,
   output logic       out_last,
   output logic       err
);

   localparam int unsigned IdxW = (WORD_TRITS > 1) ? $clog2(WORD_TRITS) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(WORD_TRITS - 1);

   localparam logic [1:0] TritM = 2'b00;
   localparam logic [1:0] TritZ = 2'b01;
   localparam logic [1:0] TritP = 2'b10;

   // Output register occupancy; out_valid is the state itself.
   typedef enum logic {StEmpty, StFull} state_e;

   state_e          state_q, state_d;
   logic [1:0]      sum_q, sum_d;
   logic [1:0]      cout_q, cout_d;
   logic            last_q, last_d;
   logic            err_q, err_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [1:0]      carry_q, carry_d;

   logic            in_xfer;
   logic            out_xfer;
   logic            is_last;
   logic signed [2:0] t;
   logic [1:0]      sum_new;
   logic [1:0]      carry_new;

   // Illegal code 11 decodes to 0 so arithmetic stays in range.
   function automatic logic signed [2:0] trit_val(input logic [1:0] code);
      logic signed [2:0] v;
      case (code)
         TritM:   v = -3'sd1;
         TritP:   v = 3'sd1;
         default: v = 3'sd0;
      endcase
      return v;
   endfunction

   assign out_valid = (state_q == StFull);
   assign out_sum   = sum_q;
   assign out_carry = cout_q;
   assign out_last  = last_q;
   assign err       = err_q;

   assign in_ready = !reset && (!out_valid || out_ready);
   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
   assign is_last  = (idx_q == LastIdx);

   // t in -3..3 fits a 3-bit signed value without overflow.
   assign t = trit_val(in_a) + trit_val(in_b) + trit_val(carry_q);

   always_comb begin
      sum_new   = TritZ;
      carry_new = TritZ;
      case (t)
         3'sb101: begin sum_new = TritZ; carry_new = TritM; end // -3
         3'sb110: begin sum_new = TritP; carry_new = TritM; end // -2
         3'sb111: begin sum_new = TritM; carry_new = TritZ; end // -1
         3'sb000: begin sum_new = TritZ; carry_new = TritZ; end
         3'sb001: begin sum_new = TritP; carry_new = TritZ; end
         3'sb010: begin sum_new = TritM; carry_new = TritP; end
         3'sb011: begin sum_new = TritZ; carry_new = TritP; end
         default: begin sum_new = TritZ; carry_new = TritZ; end
      endcase
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      last_d  = last_q;
      err_d   = err_q;
      idx_d   = idx_q;
      carry_d = carry_q;

      if (in_xfer) begin
         state_d = StFull;
         sum_d   = sum_new;
         cout_d  = carry_new;
         last_d  = is_last;
         if ((in_a == 2'b11) || (in_b == 2'b11)) begin
            err_d = 1'b1;
         end
         // Carry never crosses a word boundary; it is reported with out_last instead.
         if (is_last) begin
            idx_d   = '0;
            carry_d = TritZ;
         end else begin
            idx_d   = idx_q + 1'b1;
            carry_d = carry_new;
         end
      end else if (out_xfer) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StEmpty;
         sum_q   <= TritZ;
         cout_q  <= TritZ;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         carry_q <= TritZ;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         last_q  <= last_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
      end
   end

endmodule
